// File: rtl/mips_harvard_cpu.sv
// Single-cycle MIPS-I subset core with separate instruction/data buses.
// Branches and jumps take effect after one delay-slot instruction via a registered pending target.
module mips_harvard_cpu #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  logic [31:0] regs_q [32];
  logic [31:0] pc_q, pc_d, target_q, target_d;
  logic        pending_q, pending_d, active_q, active_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val, simm, zimm, pc4;
  logic        exec, branch;
  logic [31:0] branch_target;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  assign op     = instr_readdata[31:26];
  assign rs     = instr_readdata[25:21];
  assign rt     = instr_readdata[20:16];
  assign rd     = instr_readdata[15:11];
  assign shamt  = instr_readdata[10:6];
  assign funct  = instr_readdata[5:0];
  assign simm   = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
  assign zimm   = {16'h0000, instr_readdata[15:0]};
  assign rs_val = regs_q[rs];
  assign rt_val = regs_q[rt];
  assign pc4    = pc_q + 32'd4;
  assign exec   = active_q & clk_enable;

  assign active         = active_q;
  assign register_v0    = regs_q[2];
  assign instr_address  = pc_q;
  assign data_address   = rs_val + simm;
  assign data_writedata = rt_val;
  // Gated with reset so strobes are low while reset is held, even with active_q=1.
  assign data_read      = reset & exec & (op == 6'h23);
  assign data_write     = reset & exec & (op == 6'h2B);

  always_comb begin
    wr_en         = 1'b0;
    wr_addr       = rt;
    wr_data       = '0;
    branch        = 1'b0;
    branch_target = '0;
    case (op)
      6'h00: begin
        wr_addr = rd;
        wr_en   = 1'b1;
        case (funct)
          6'h00: wr_data = rt_val << shamt;
          6'h02: wr_data = rt_val >> shamt;
          6'h03: wr_data = $signed(rt_val) >>> shamt;
          6'h08: begin wr_en = 1'b0; branch = 1'b1; branch_target = rs_val; end
          6'h09: begin branch = 1'b1; branch_target = rs_val; wr_data = pc_q + 32'd8; end
          6'h21: wr_data = rs_val + rt_val;
          6'h23: wr_data = rs_val - rt_val;
          6'h24: wr_data = rs_val & rt_val;
          6'h25: wr_data = rs_val | rt_val;
          6'h26: wr_data = rs_val ^ rt_val;
          6'h27: wr_data = ~(rs_val | rt_val);
          6'h2A: wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: wr_data = {31'd0, rs_val < rt_val};
          default: wr_en = 1'b0;
        endcase
      end
      6'h02: begin branch = 1'b1; branch_target = {pc4[31:28], instr_readdata[25:0], 2'b00}; end
      6'h03: begin
        branch = 1'b1;
        branch_target = {pc4[31:28], instr_readdata[25:0], 2'b00};
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = pc_q + 32'd8;
      end
      6'h04: begin branch = (rs_val == rt_val); branch_target = pc4 + (simm << 2); end
      6'h05: begin branch = (rs_val != rt_val); branch_target = pc4 + (simm << 2); end
      6'h09: begin wr_en = 1'b1; wr_data = rs_val + simm; end
      6'h0A: begin wr_en = 1'b1; wr_data = {31'd0, $signed(rs_val) < $signed(simm)}; end
      6'h0B: begin wr_en = 1'b1; wr_data = {31'd0, rs_val < simm}; end
      6'h0C: begin wr_en = 1'b1; wr_data = rs_val & zimm; end
      6'h0D: begin wr_en = 1'b1; wr_data = rs_val | zimm; end
      6'h0E: begin wr_en = 1'b1; wr_data = rs_val ^ zimm; end
      6'h0F: begin wr_en = 1'b1; wr_data = {instr_readdata[15:0], 16'h0000}; end
      6'h23: begin wr_en = 1'b1; wr_data = data_readdata; end
      default: ;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    pending_d = pending_q;
    target_d  = target_q;
    active_d  = active_q;
    if (exec) begin
      pc_d      = pending_q ? target_q : pc4;
      pending_d = branch;
      target_d  = branch_target;
      active_d  = (pc_d != 32'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_VECTOR;
      target_q  <= '0;
      pending_q <= 1'b0;
      active_q  <= 1'b1;
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      target_q  <= target_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      if (exec && wr_en && wr_addr != 5'd0) regs_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mips_harvard_cpu.sv
// Directed-program bench for mips_harvard_cpu with behavioural instruction and data memories.
module tb_mips_harvard_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        active;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_write, data_read;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  logic [31:0] idx;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_harvard_cpu #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .clk_enable(clk_enable), .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_address(data_address), .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  assign idx            = (instr_address - 32'hBFC00000) >> 2;
  assign instr_readdata = (idx < 32'd64) ? imem[idx[5:0]] : 32'h0;
  assign data_readdata  = dmem[data_address[5:2]];

  always @(posedge clk) if (data_write) dmem[data_address[5:2]] <= data_writedata;

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_to_halt();
    int n = 0;
    while (instr_address !== 32'h0 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_halt(input string name, input logic [31:0] exp_v0);
    vectors++;
    if (instr_address !== 32'h0 || active !== 1'b0 || register_v0 !== exp_v0) begin
      miscompares++;
      $display("FAIL %s: pc=%h active=%b v0=%h, required pc=0 active=0 v0=%h",
               name, instr_address, active, register_v0, exp_v0);
    end
  endtask

  task automatic load_beq();
    clear_mem();
    imem[0] = 32'h10640002;  // BEQ $3,$4,+2
    imem[1] = 32'h24420001;
    imem[2] = 32'h24420001;
    imem[3] = 32'h24420001;
    imem[4] = 32'h00000008;  // JR $0
    imem[5] = 32'h00000000;
  endtask

  task automatic load_bne();
    clear_mem();
    imem[0] = 32'h14000002;  // BNE $0,$0,+2
    imem[1] = 32'h24420001;
    imem[2] = 32'h24420001;
    imem[3] = 32'h24420001;
    imem[4] = 32'h00000008;
    imem[5] = 32'h00000000;
  endtask

  task automatic test_reset();
    load_beq();
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (instr_address !== 32'hBFC00000 || register_v0 !== 32'h0 || active !== 1'b1 ||
        data_write !== 1'b0 || data_read !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: pc=%h v0=%h active=%b wr=%b rd=%b, required BFC00000/0/1/0/0",
               instr_address, register_v0, active, data_write, data_read);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_beq_taken();
    load_beq();
    do_reset();
    @(negedge clk);
    vectors++;
    if (instr_address !== 32'hBFC00004) begin
      miscompares++;
      $display("FAIL beq_delay_slot_pc: got %h, required BFC00004", instr_address);
    end
    @(negedge clk);
    vectors++;
    if (instr_address !== 32'hBFC0000C || register_v0 !== 32'd1) begin
      miscompares++;
      $display("FAIL beq_target: pc=%h v0=%h, required BFC0000C/1", instr_address, register_v0);
    end
    run_to_halt();
    check_halt("beq_halt", 32'd2);
    repeat (3) @(negedge clk);
    check_halt("halt_hold", 32'd2);
  endtask

  task automatic test_bne_not_taken();
    load_bne();
    do_reset();
    run_to_halt();
    check_halt("bne_halt", 32'd3);
  endtask

  task automatic test_load_store();
    clear_mem();
    imem[0] = 32'h24030055;  // ADDIU $3,$0,0x55
    imem[1] = 32'hAC030004;  // SW $3,4($0)
    imem[2] = 32'h8C020004;  // LW $2,4($0)
    imem[3] = 32'h00000008;
    imem[4] = 32'h00000000;
    do_reset();
    vectors++;
    if (data_write !== 1'b0 || data_read !== 1'b0) begin
      miscompares++;
      $display("FAIL addiu_strobes: wr=%b rd=%b, required 0/0", data_write, data_read);
    end
    @(negedge clk);
    vectors++;
    if (data_write !== 1'b1 || data_read !== 1'b0 || data_address !== 32'd4 ||
        data_writedata !== 32'h55) begin
      miscompares++;
      $display("FAIL sw_cycle: wr=%b rd=%b addr=%h wdata=%h, required 1/0/4/55",
               data_write, data_read, data_address, data_writedata);
    end
    @(negedge clk);
    vectors++;
    if (data_read !== 1'b1 || data_write !== 1'b0 || data_address !== 32'd4) begin
      miscompares++;
      $display("FAIL lw_cycle: rd=%b wr=%b addr=%h, required 1/0/4", data_read, data_write, data_address);
    end
    run_to_halt();
    check_halt("ls_halt", 32'h55);
  endtask

  task automatic test_jal_link();
    clear_mem();
    imem[0]  = 32'h0FF00010;  // JAL 0xBFC00040
    imem[1]  = 32'h00000000;
    imem[16] = 32'h03E01021;  // ADDU $2,$31,$0
    imem[17] = 32'h00000008;
    imem[18] = 32'h00000000;
    do_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (instr_address !== 32'hBFC00040) begin
      miscompares++;
      $display("FAIL jal_target: got %h, required BFC00040", instr_address);
    end
    run_to_halt();
    check_halt("jal_halt", 32'hBFC00008);
  endtask

  task automatic test_alu();
    logic [31:0] exp [5];
    exp = '{32'h12340000, 32'h12348765, 32'hFFFFFFFF, 32'h0FFFFFFF, 32'h00000001};
    clear_mem();
    imem[0] = 32'h3C021234;  // LUI $2,0x1234
    imem[1] = 32'h34428765;  // ORI $2,$2,0x8765
    imem[2] = 32'h2402FFFF;  // ADDIU $2,$0,-1
    imem[3] = 32'h00021102;  // SRL $2,$2,4
    imem[4] = 32'h0002102B;  // SLTU $2,$0,$2
    imem[5] = 32'h00000008;
    imem[6] = 32'h00000000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (register_v0 !== exp[i]) begin
        miscompares++;
        $display("FAIL alu_step%0d: got %h, required %h", i, register_v0, exp[i]);
      end
    end
    run_to_halt();
    check_halt("alu_halt", 32'h1);
  endtask

  task automatic test_reset_mid_run();
    load_beq();
    do_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (register_v0 !== 32'd1) begin
      miscompares++;
      $display("FAIL midrun_pre: v0=%h, required 1", register_v0);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (instr_address !== 32'hBFC00000 || register_v0 !== 32'h0 || active !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_reset: pc=%h v0=%h active=%b, required BFC00000/0/1",
               instr_address, register_v0, active);
    end
    @(negedge clk);
    reset = 1'b1;
    run_to_halt();
    check_halt("midrun_rerun", 32'd2);
  endtask

  task automatic test_stall();
    load_bne();
    do_reset();
    repeat (3) @(negedge clk);
    clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (instr_address !== 32'hBFC0000C || register_v0 !== 32'd2 || active !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: pc=%h v0=%h active=%b, required BFC0000C/2/1",
                 i, instr_address, register_v0, active);
      end
    end
    clk_enable = 1'b1;
    run_to_halt();
    check_halt("stall_halt", 32'd3);
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_load_store();
    test_jal_link();
    test_alu();
    test_reset_mid_run();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_harvard_cpu.md
Name: mips_harvard_cpu

Overview:
- Single-cycle, 32-bit MIPS-I subset CPU with a Harvard interface: separate instruction and data buses.
- Fetches from external instruction memory at instr_address and accesses an external data memory.
- Exposes $v0 (r2) for result checking.
- Sits at the top of the CPU test environment; halts after a jump to address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value after reset.

Ports:
- clk  input  1  system clock; state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- active  output  1  high while executing; low once halted.
- register_v0  output  32  live contents of r2 ($v0).
- clk_enable  input  1  when low, no architectural state (PC, registers, delay state) changes.
- instr_address  output  32  current PC; word aligned.
- instr_readdata  input  32  instruction at instr_address, combinational, same cycle.
- data_address  output  32  load/store byte address (rs + sign-extended imm).
- data_write  output  1  high during SW.
- data_read  output  1  high during LW.
- data_writedata  output  32  rt value for SW.
- data_readdata  input  32  load data, valid combinationally in the same cycle as data_read.

Behaviour:
- Reset is asynchronous and active-low: while reset=0, the following are forced:
  - PC=RESET_VECTOR
  - all 32 GPRs = 0
  - delay-slot state cleared
  - active=1
  - data_write=0, data_read=0
- Single-cycle execution: one instruction retires per rising clk edge with clk_enable=1.
- r0 reads 0 always; writes to r0 are discarded (e.g. addiu $0,$0,0 is a NOP).
- Supported instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR.
  - I-type: ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE.
  - J-type: J, JAL.
- Immediate and arithmetic rules:
  - Arithmetic immediates are sign-extended.
  - Logical immediates (ANDI/ORI/XORI) are zero-extended.
  - No overflow traps; all arithmetic wraps mod 2^32.
- Branch target = PC+4 + (sign-extended imm << 2).
  - BEQ/BNE compare rs and rt.
  - Example: BEQ at 0xBFC00000 with imm=2 targets 0xBFC0000C.
- Branch delay slot: every branch/jump, taken or not, executes the following instruction before control transfers. Implementation:
  - Register a pending target and a pending flag.
  - Next PC is the target when pending, else PC+4.
- Jump targets:
  - J/JAL: {PC+4[31:28], index, 2'b00}.
  - JR/JALR: target = rs.
  - JAL/JALR link r31 (JALR: rd) with PC+8.
- Memory handshake:
  - data_read and data_write are each asserted for exactly the cycle of the LW/SW; they are never both high.
  - The LW result is written to rt on the same edge.
- Halt:
  - When PC becomes 0x00000000 (e.g. after JR $0 and its delay slot), active drops to 0 on that edge.
  - The CPU then stops fetching/updating (PC held at 0, no register or memory writes).
  - register_v0 stays stable; active remains 0 until reset.
- clk_enable=0: all state is held; memory strobes are deasserted.
- Unsupported opcodes execute as NOP.
- register_v0 is combinationally equal to GPR r2.

Test Plan:
- Taken BEQ with delay slot:
  - Program at BFC00000:
    - BEQ $3,$4,+2
    - ADDIU $2,$2,1
    - ADDIU $2,$2,1
    - ADDIU $2,$2,1
    - JR $0
    - ADDIU $0,$0,0
  - Required: when instr_address==0, register_v0==2 and active==0.
- Not-taken BNE:
  - BNE $0,$0,+2, then three ADDIU $2,$2,1, then JR $0 and a NOP.
  - Required: v0==3 at halt.
- Load/store round trip:
  - Sequence: ADDIU $3,$0,0x55; SW $3,4($0); LW $2,4($0); JR $0; NOP.
  - Required:
    - data_write=1 with data_address=4 and data_writedata=0x55 in the SW cycle.
    - v0==0x55 at halt.
- JAL link:
  - JAL at BFC00000 to a target that does ADDU $2,$31,$0, then JR $0.
  - Required: v0==0xBFC00008.
- Reset mid-run:
  - Assert reset=0 asynchronously mid-program.
  - Required: instr_address==0xBFC00000 immediately, v0==0, active==1.
  - After release, the program reruns to the same halt values.
- clk_enable low for 5 cycles mid-program:
  - Required: PC and v0 unchanged during the stall; the final v0 matches the unstalled run.
